fifo_wr_arbiter: RTL and testbench
==================================

# fifo_wr_arbiter

Round-robin write arbiter that lets N_REQ producers share the write port of one `fifo_simple` instance. Each requester presents a word with a valid/ack handshake. The arbiter grants one requester at a time for a bounded burst and steers that requester's data onto the FIFO write port. It throttles on the FIFO's `full` and `prog_full` flags so the FIFO never sees a write while full. The block sits directly in front of the FIFO; the FIFO read side is untouched.

## Interface
Parameters:
- WIDTH, 16, data word width; must match the FIFO's WIDTH.
- N_REQ, 4, number of requesters (2..8).
- MAX_BURST, 4, maximum words accepted per grant (1..16).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_i  in  N_REQ  per-requester valid; requester i has a word ready.
- data_i  in  N_REQ*WIDTH  requester i's word on bits [i*WIDTH +: WIDTH].
- ack_o  out  N_REQ  word from requester i accepted this cycle.
- fifo_data_o  out  WIDTH  connects to the FIFO `data_i`.
- fifo_we_o  out  1  connects to the FIFO `data_we`.
- fifo_full_i  in  1  from the FIFO `full`.
- fifo_prog_full_i  in  1  from the FIFO `prog_full`.
- grant_id_o  out  clog2(N_REQ)  index of the current or last granted requester.
- active_o  out  1  high while in the GRANT state.

## Operation
- FSM has two states.
  - IDLE: no transfer takes place.
  - GRANT: transfers from requester `grant_id_o`.
- **Round robin**
  - The `last` register holds the last granted index.
  - The search starts at `last+1` mod N_REQ and takes the first i with `req_i[i]`=1.
- **IDLE → GRANT**
  - Taken when any `req_i` is high and `fifo_prog_full_i`=0.
  - At that edge: `grant_id_o` and `last` ← selected index, `burst_cnt` ← 0.
  - Otherwise the FSM stays in IDLE.
- **In GRANT**
  - Transfer condition is `xfer` = `req_i[grant_id_o]` & ~`fifo_full_i`. It is combinational.
  - `fifo_we_o` = `xfer`.
  - `ack_o[grant_id_o]` = `xfer`; all other ack bits are 0.
  - `fifo_data_o` = the granted slice of `data_i`. It is a mux and is valid even when `fifo_we_o`=0.
  - On each `xfer`, `burst_cnt` increments. `burst_cnt` is 4 bits and saturation is never reached.
- **GRANT → IDLE** at the edge where any of the following holds:
  - `req_i[grant_id_o]`=0.
  - `xfer` and `burst_cnt`==MAX_BURST-1.
  - `xfer` and `fifo_prog_full_i`=1.
- While in GRANT with `req_i[grant_id_o]`=1 and `fifo_full_i`=1:
  - The FSM holds GRANT with no transfer.
  - `burst_cnt` is unchanged.
- In IDLE, `ack_o`=0 and `fifo_we_o`=0.
- Requester contract: `data_i` slice and `req_i` stay stable from assertion until ack. The word is consumed in the ack cycle.
- Reset values:
  - state = IDLE.
  - `grant_id_o` = 0.
  - `last` = N_REQ-1, so requester 0 wins first.
  - `burst_cnt` = 0.
  - `active_o` = 0, `ack_o` = 0, `fifo_we_o` = 0.

## Timing
- **Arbitration latency:**
  - `req_i` rises in cycle t while the FSM is IDLE.
  - The FSM enters GRANT at edge t+1.
  - The first ack/write is in cycle t+1.
- **Throughput:** up to MAX_BURST consecutive words per grant. Each re-grant costs one IDLE bubble cycle.
- `fifo_full_i` is sampled combinationally in the same cycle as the write, so `fifo_we_o` is never high while `fifo_full_i`=1.
- `fifo_prog_full_i`:
  - Ends the burst after the current transfer.
  - Blocks new grants until it deasserts.
- **Reset:**
  - Assertion of `reset_n` forces all outputs to reset values immediately (async), including mid-burst.
  - An in-flight word is not written.
  - Release is synchronous to `clk` by the integrating top.
- **Simultaneous requests:** exactly one grant per IDLE cycle, ordered as above.

## Test plan
- **Reset:**
  - Stimulus: `reset_n`=0 with `req_i`=4'b1111.
  - Response: `ack_o`=0, `fifo_we_o`=0, `grant_id_o`=0, `active_o`=0.
  - After release, requester 0 is granted first.
- **Round robin:**
  - Stimulus: `req_i`=4'b1111 held, MAX_BURST=4, FIFO drained continuously.
  - Response: grant order 0,1,2,3,0.
  - Each grant gives 4 acks, then 1 idle cycle.
- **Short request:**
  - Stimulus: requester 2 raises `req_i` for 2 words, then drops.
  - Response: 2 acks, then back to IDLE.
  - The next grant goes to the first requester after index 2.
- **Full stall:**
  - Stimulus: force `fifo_full_i`=1 during a burst for 3 cycles.
  - Response: `fifo_we_o`=0 for those 3 cycles, GRANT is held and `burst_cnt` is unchanged.
  - The remaining words are written after `fifo_full_i` drops.
- **Prog-full throttle:**
  - Stimulus: connect a real FIFO with DEPTH=16 and PROG_FULL=14, with no reads.
  - Response: the burst ends on the write where `fifo_prog_full_i` is sampled high, and no further grants follow.
  - The FIFO `overflow` output stays 0.
  - Reading 2 words resumes grants.
- **Async reset mid-burst:**
  - Stimulus: drop `reset_n` in the 2nd cycle of a burst.
  - Response: `fifo_we_o` and `ack_o` go 0 without a clock edge.
  - After release, the FSM is IDLE and requester 0 has priority.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N_REQ producers share one FIFO write port with
// bounded bursts, throttled by the FIFO full and prog_full flags.
module fifo_wr_arbiter #(
   parameter int WIDTH     = 16,
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 4,
   localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic [N_REQ-1:0]         req_i,
   input  logic [N_REQ*WIDTH-1:0]   data_i,
   output logic [N_REQ-1:0]         ack_o,
   output logic [WIDTH-1:0]         fifo_data_o,
   output logic                     fifo_we_o,
   input  logic                     fifo_full_i,
   input  logic                     fifo_prog_full_i,
   output logic [GW-1:0]            grant_id_o,
   output logic                     active_o
);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_e;

   localparam logic [3:0]    BURST_LAST = 4'(MAX_BURST - 1);
   localparam logic [GW-1:0] LAST_RST   = GW'(N_REQ - 1);

   state_e          state_q, state_d;
   logic [GW-1:0]   grant_q, grant_d;
   logic [GW-1:0]   last_q,  last_d;
   logic [3:0]      burst_q, burst_d;
   logic [GW-1:0]   pick_s;
   logic            xfer_s;

   // First requester at or after last+1 (wrapping); returns last when none asserted.
   function automatic logic [GW-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                             input logic [GW-1:0]    last);
      logic [GW-1:0] pick;
      logic          found;
      int            idx;
      pick  = last;
      found = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last) + k) % N_REQ;
         if (!found && req[idx]) begin
            pick  = GW'(idx);
            found = 1'b1;
         end
      end
      return pick;
   endfunction

   assign pick_s = rr_pick(req_i, last_q);

   // Next-state, burst accounting and the combinational write/ack path.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_d      = last_q;
      burst_d     = burst_q;
      xfer_s      = 1'b0;
      fifo_data_o = data_i[int'(grant_q)*WIDTH +: WIDTH];
      case (state_q)
         ST_IDLE: begin
            if ((|req_i) && !fifo_prog_full_i) begin
               state_d = ST_GRANT;
               grant_d = pick_s;
               last_d  = pick_s;
               burst_d = 4'd0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_GRANT: begin
            xfer_s = req_i[grant_q] & ~fifo_full_i;
            if (!req_i[grant_q]) begin
               state_d = ST_IDLE;
            end else if (xfer_s) begin
               burst_d = burst_q + 4'd1;
               // prog_full lets the current word through but closes the burst.
               if ((burst_q == BURST_LAST) || fifo_prog_full_i) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_GRANT;
               end
            end else begin
               state_d = ST_GRANT;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      fifo_we_o = xfer_s;
      ack_o     = xfer_s ? (N_REQ'(1) << grant_q) : '0;
   end

   // State, grant, round-robin pointer and burst counter registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         grant_q <= '0;
         last_q  <= LAST_RST;
         burst_q <= 4'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         burst_q <= burst_d;
      end
   end

   assign grant_id_o = grant_q;
   assign active_o   = (state_q == ST_GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed vector table, directed
// corner sequences and randomized traffic against a rule-level model with a FIFO.
module tb_fifo_wr_arbiter;

   localparam int W     = 16;
   localparam int N     = 4;
   localparam int MB    = 4;
   localparam int DEPTH = 16;
   localparam int PF    = 14;

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] data = '0;
   logic           full = 1'b0;
   logic           pfull = 1'b0;
   logic [N-1:0]   ack;
   logic [W-1:0]   fdata;
   logic           we;
   logic [1:0]     gid;
   logic           active;

   fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_BURST(MB)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .req_i            (req),
      .data_i           (data),
      .ack_o            (ack),
      .fifo_data_o      (fdata),
      .fifo_we_o        (we),
      .fifo_full_i      (full),
      .fifo_prog_full_i (pfull),
      .grant_id_o       (gid),
      .active_o         (active)
   );

   always #5 clk = ~clk;

   int n_pass  = 0;
   int n_total = 0;

   // Rule-level model: owner (-1 = nobody), words taken this grant, last winner.
   int m_owner, m_taken, m_last, m_gid;
   // Environment: FIFO occupancy and per-requester pending words.
   int           fcnt, overflow_cnt;
   logic [N-1:0] pend;
   logic [W-1:0] word [N];

   typedef struct {
      logic [3:0] req;
      logic       full;
      logic       pf;
      logic [3:0] ack;
      logic       we;
      logic [1:0] gid;
      logic       act;
   } vec_t;
   vec_t tbl [32];

   function automatic vec_t mk(input logic [3:0] r, input logic f, input logic p,
                               input logic [3:0] a, input logic w, input logic [1:0] g,
                               input logic act);
      vec_t v;
      v.req = r; v.full = f; v.pf = p; v.ack = a; v.we = w; v.gid = g; v.act = act;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_owner = -1; m_taken = 0; m_last = N - 1; m_gid = 0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic f, input logic p,
                             output logic [N-1:0] e_ack, output logic e_we,
                             output int e_gid, output logic e_act);
      logic found;
      e_ack = '0; e_we = 1'b0; e_gid = m_gid; e_act = (m_owner >= 0);
      if (m_owner >= 0) begin
         if (!r[m_owner]) m_owner = -1;
         else if (!f) begin
            e_we = 1'b1;
            e_ack[m_owner] = 1'b1;
            m_taken++;
            if (m_taken == MB || p) m_owner = -1;
         end
      end else if (r != '0 && !p) begin
         found = 1'b0;
         for (int k = 1; k <= N; k++) begin
            if (!found && r[(m_last + k) % N]) begin
               m_owner = (m_last + k) % N;
               found = 1'b1;
            end
         end
         m_gid = m_owner; m_last = m_owner; m_taken = 0;
      end
   endtask

   task automatic apply_reset();
      reset_n = 1'b0; req = '0; full = 1'b0; pfull = 1'b0;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      model_reset();
      fcnt = 0; overflow_cnt = 0; pend = '0;
      for (int i = 0; i < N; i++) word[i] = W'(16'hA000 + i);
   endtask

   // One checked cycle; caller has already aligned to the negative edge.
   task automatic do_cycle(input logic [N-1:0] r, input logic f, input logic p, input logic rd);
      logic [N-1:0] e_ack;
      logic         e_we;
      int           e_gid;
      logic         e_act;
      req = r; full = f; pfull = p;
      for (int i = 0; i < N; i++) data[i*W +: W] = word[i];
      #2;
      model_step(r, f, p, e_ack, e_we, e_gid, e_act);
      check("ack", 32'(ack), 32'(e_ack));
      check("we", 32'(we), 32'(e_we));
      check("gid", 32'(gid), 32'(e_gid));
      check("active", 32'(active), 32'(e_act));
      if (e_act) check("fifo_data", 32'(fdata), 32'(word[e_gid]));
      if (we && f) overflow_cnt++;
      for (int i = 0; i < N; i++) if (ack[i]) pend[i] = 1'b0;
      fcnt = fcnt + (we ? 1 : 0) - (rd ? 1 : 0);
   endtask

   task automatic run_cycle(input int rd_mode, input int prob);
      logic f, p, rd;
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
         if (!pend[i] && int'($urandom_range(99)) < prob) begin
            pend[i] = 1'b1;
            word[i] = W'($urandom);
         end
      end
      f  = (fcnt >= DEPTH) || (rd_mode == 1 && $urandom_range(7) == 0);
      p  = (fcnt >= PF);
      rd = (fcnt > 0) && (rd_mode == 2 || (rd_mode == 1 && $urandom_range(2) == 0));
      do_cycle(pend, f, p, rd);
   endtask

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  n_ack2;
      logic seen;

      // Reset holds everything quiet even with all requesters asserted.
      reset_n = 1'b0; req = 4'b1111;
      #3;
      check("rst_ack", 32'(ack), 32'd0);
      check("rst_we", 32'(we), 32'd0);
      check("rst_gid", 32'(gid), 32'd0);
      check("rst_active", 32'(active), 32'd0);
      apply_reset();

      tbl[0] = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
      for (int i = 1; i <= 4; i++)   tbl[i] = mk(4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
      tbl[5] = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
      for (int i = 6; i <= 9; i++)   tbl[i] = mk(4'b1111, 1'b0, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1);
      tbl[10] = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd1, 1'b0);
      for (int i = 11; i <= 13; i++) tbl[i] = mk(4'b1111, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b1);
      for (int i = 14; i <= 17; i++) tbl[i] = mk(4'b1111, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1);
      tbl[18] = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
      for (int i = 19; i <= 22; i++) tbl[i] = mk(4'b1111, 1'b0, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1);
      tbl[23] = mk(4'b1111, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd3, 1'b0);
      tbl[24] = mk(4'b1111, 1'b0, 1'b0, 4'b0001, 1'b1, 2'd0, 1'b1);
      tbl[25] = mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b1);
      tbl[26] = mk(4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
      tbl[27] = mk(4'b0100, 1'b0, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0);
      tbl[28] = mk(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0);
      tbl[29] = mk(4'b0100, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd2, 1'b1);
      tbl[30] = mk(4'b0100, 1'b0, 1'b0, 4'b0000, 1'b0, 2'd2, 1'b0);
      tbl[31] = mk(4'b0100, 1'b0, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1);

      for (int i = 0; i < N; i++) data[i*W +: W] = W'(16'hA000 + i);
      for (int i = 0; i < 32; i++) begin
         @(negedge clk);
         req = tbl[i].req; full = tbl[i].full; pfull = tbl[i].pf;
         #2;
         check($sformatf("tbl%0d_ack", i), 32'(ack), 32'(tbl[i].ack));
         check($sformatf("tbl%0d_we", i), 32'(we), 32'(tbl[i].we));
         check($sformatf("tbl%0d_gid", i), 32'(gid), 32'(tbl[i].gid));
         check($sformatf("tbl%0d_active", i), 32'(active), 32'(tbl[i].act));
         if (tbl[i].act) check($sformatf("tbl%0d_data", i), 32'(fdata), 32'(16'hA000 + tbl[i].gid));
      end

      // Short request from requester 2, then the next grant must go to 3.
      apply_reset();
      n_ack2 = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         do_cycle((c < 3) ? 4'b0100 : 4'b0000, 1'b0, 1'b0, 1'b0);
         if (ack[2]) n_ack2++;
      end
      check("short_acks", 32'(n_ack2), 32'd2);
      @(negedge clk); do_cycle(4'b1111, 1'b0, 1'b0, 1'b0);
      @(negedge clk); do_cycle(4'b1111, 1'b0, 1'b0, 1'b0);
      check("short_next_gid", 32'(gid), 32'd3);

      // Async reset in the second cycle of a burst.
      apply_reset();
      @(negedge clk); do_cycle(4'b0100, 1'b0, 1'b0, 1'b0);
      @(negedge clk); do_cycle(4'b0100, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      req = 4'b0100;
      #2;
      check("arst_pre_we", 32'(we), 32'd1);
      reset_n = 1'b0;
      #1;
      check("arst_we", 32'(we), 32'd0);
      check("arst_ack", 32'(ack), 32'd0);
      check("arst_active", 32'(active), 32'd0);
      check("arst_gid", 32'(gid), 32'd0);
      @(negedge clk);
      req = '0;
      reset_n = 1'b1;
      model_reset();
      @(negedge clk); do_cycle(4'b1111, 1'b0, 1'b0, 1'b0);
      @(negedge clk); do_cycle(4'b1111, 1'b0, 1'b0, 1'b0);
      check("arst_first_gid", 32'(gid), 32'd0);

      // Prog-full throttle with a non-draining FIFO of depth 16, threshold 14.
      apply_reset();
      for (int c = 0; c < 60; c++) run_cycle(0, 100);
      check("pf_fifo_level", 32'(fcnt), 32'd15);
      check("pf_overflow", 32'(overflow_cnt), 32'd0);
      check("pf_idle", 32'(active), 32'd0);
      run_cycle(2, 100);
      run_cycle(2, 100);
      seen = 1'b0;
      for (int c = 0; c < 10; c++) begin
         run_cycle(0, 100);
         if (active) seen = 1'b1;
      end
      check("pf_resume", 32'(seen), 32'd1);
      check("pf_overflow_end", 32'(overflow_cnt), 32'd0);

      // Randomized traffic, random drain and random full pulses.
      apply_reset();
      for (int c = 0; c < 3000; c++) run_cycle(1, 30);
      check("rand_overflow", 32'(overflow_cnt), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
